// File: rtl/program_mem.sv
// Small instruction memory with a single-cycle fetch port and a sequential
// program-load port that rewrites the whole memory from address 0 upward.
module program_mem #(
    parameter int                 DATA_W   = 16,
    parameter int                 ADDR_W   = 3,
    parameter logic [DATA_W-1:0]  NOP_WORD = DATA_W'(16'h000F)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                fetch_req,
    input  logic [ADDR_W-1:0]   fetch_addr,
    output logic                fetch_ready,
    output logic                inst_valid,
    output logic [DATA_W-1:0]   inst,
    input  logic                load_start,
    input  logic                load_valid,
    input  logic [DATA_W-1:0]   load_data,
    output logic                load_ready,
    output logic                load_done,
    output logic [ADDR_W:0]     load_count
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        RUN  = 1'b0,
        LOAD = 1'b1
    } state_t;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   ptr_reg, ptr_next;
    logic [ADDR_W:0]     count_reg, count_next;
    logic                load_done_reg, load_done_next;
    logic [DATA_W-1:0]   inst_reg;
    logic                inst_valid_reg;
    logic                fetch_accept;
    logic                load_write;
    logic [DEPTH-1:0]    word_we;

    // Every word must return to NOP_WORD on reset, so the storage is a
    // register array rather than an inferred block RAM.
    logic [DATA_W-1:0]   mem_reg [DEPTH];

    assign fetch_ready = (state_reg == RUN);
    assign load_ready  = (state_reg == LOAD);

    assign fetch_accept = fetch_req && (state_reg == RUN);
    // A restart takes priority, so a word presented with load_start is dropped.
    assign load_write   = (state_reg == LOAD) && load_valid && !load_start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= RUN;
            ptr_reg       <= '0;
            count_reg     <= '0;
            load_done_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            ptr_reg       <= ptr_next;
            count_reg     <= count_next;
            load_done_reg <= load_done_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        ptr_next       = ptr_reg;
        count_next     = count_reg;
        load_done_next = 1'b0;
        case (state_reg)
            RUN: begin
                if (load_start) begin
                    state_next = LOAD;
                    ptr_next   = '0;
                    count_next = '0;
                end
            end
            LOAD: begin
                if (load_start) begin
                    ptr_next   = '0;
                    count_next = '0;
                end else if (load_valid) begin
                    // ptr is ADDR_W bits wide, so it wraps to 0 after the last word
                    ptr_next   = ptr_reg + 1'b1;
                    count_next = count_reg + 1'b1;
                    if (count_reg == (ADDR_W + 1)'(DEPTH - 1)) begin
                        state_next     = RUN;
                        load_done_next = 1'b1;
                    end
                end
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word_we
        assign word_we[gi] = load_write && (ptr_reg == ADDR_W'(gi));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= NOP_WORD;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (word_we[i]) begin
                    mem_reg[i] <= load_data;
                end
            end
        end
    end

    // Read captures the pre-write contents, so a fetch accepted alongside
    // load_start returns the old program.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_reg       <= '0;
            inst_valid_reg <= 1'b0;
        end else begin
            inst_valid_reg <= fetch_accept;
            if (fetch_accept) begin
                inst_reg <= mem_reg[fetch_addr];
            end
        end
    end

    assign inst       = inst_reg;
    assign inst_valid = inst_valid_reg;
    assign load_done  = load_done_reg;
    assign load_count = count_reg;

endmodule

// File: tb/tb_program_mem.sv
// Self-checking bench for program_mem: directed scenarios plus a randomized
// run, all checked against an array-based reference model of the memory.
module tb_program_mem;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 8;
    localparam logic [15:0] NOP = 16'h000F;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              fetch_req = 1'b0;
    logic [ADDR_W-1:0] fetch_addr = '0;
    logic              fetch_ready;
    logic              inst_valid;
    logic [DATA_W-1:0] inst;
    logic              load_start = 1'b0;
    logic              load_valid = 1'b0;
    logic [DATA_W-1:0] load_data = '0;
    logic              load_ready;
    logic              load_done;
    logic [ADDR_W:0]   load_count;

    program_mem #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NOP_WORD (NOP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_ready (fetch_ready),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .load_start  (load_start),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_ready  (load_ready),
        .load_done   (load_done),
        .load_count  (load_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: memory contents, whether a load is in progress and
    // how many words of it have arrived, plus expected registered outputs.
    logic [15:0] m_mem [DEPTH];
    bit          m_load;
    int          m_count;
    logic [15:0] exp_inst;
    bit          exp_valid;
    bit          exp_done;

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = NOP;
        m_load    = 1'b0;
        m_count   = 0;
        exp_inst  = 16'h0000;
        exp_valid = 1'b0;
        exp_done  = 1'b0;
    endtask

    // Apply the current inputs for one clock edge, update the model, and
    // return 1 time unit after the edge.
    task automatic tick();
        bit          acc;
        logic [15:0] rd;
        bit          done;
        acc  = fetch_req && !m_load;
        rd   = m_mem[fetch_addr];
        done = 1'b0;
        if (load_start) begin
            m_load  = 1'b1;
            m_count = 0;
        end else if (m_load && load_valid) begin
            m_mem[m_count % DEPTH] = load_data;
            m_count++;
            if (m_count == DEPTH) begin
                m_load = 1'b0;
                done   = 1'b1;
            end
        end
        exp_valid = acc;
        if (acc) exp_inst = rd;
        exp_done = done;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        fetch_req  = 1'b0;
        load_start = 1'b0;
        load_valid = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        #1;
        total++;
        if (inst !== 16'h0000) begin bad++; $display("FAIL reset_inst got=%h want=0000", inst); end
        total++;
        if (inst_valid !== 1'b0) begin bad++; $display("FAIL reset_inst_valid got=%b want=0", inst_valid); end
        total++;
        if (load_done !== 1'b0) begin bad++; $display("FAIL reset_load_done got=%b want=0", load_done); end
        total++;
        if (load_count !== 4'd0) begin bad++; $display("FAIL reset_load_count got=%0d want=0", load_count); end
        total++;
        if (fetch_ready !== 1'b1 || load_ready !== 1'b0) begin
            bad++; $display("FAIL reset_ready got=%b%b want=10", fetch_ready, load_ready);
        end
        #1;
        rst_n = 1'b1;
        tick();
        total++;
        if (inst_valid !== 1'b0 || inst !== 16'h0000) begin
            bad++; $display("FAIL post_reset_idle got=%b/%h want=0/0000", inst_valid, inst);
        end
    endtask

    task automatic test_fetch_all();
        for (int a = 0; a < DEPTH; a++) begin
            fetch_req  = 1'b1;
            fetch_addr = ADDR_W'(a);
            tick();
            $display("fetch addr=%0d inst=%h valid=%b", a, inst, inst_valid);
            total++;
            if (inst_valid !== 1'b1 || inst !== NOP) begin
                bad++; $display("FAIL nop_fetch addr=%0d got=%b/%h want=1/%h", a, inst_valid, inst, NOP);
            end
        end
        fetch_req = 1'b0;
        tick();
        total++;
        if (inst_valid !== 1'b0 || inst !== NOP) begin
            bad++; $display("FAIL fetch_hold got=%b/%h want=0/%h", inst_valid, inst, NOP);
        end
    endtask

    task automatic test_load_gaps();
        logic [15:0] words [DEPTH];
        int          pulses;
        words = '{16'h1215, 16'h140A, 16'h000F, 16'h000F, 16'hF201, 16'hF402, 16'hF203, 16'hF404};
        pulses = 0;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        total++;
        if (load_ready !== 1'b1 || fetch_ready !== 1'b0 || load_count !== 4'd0) begin
            bad++; $display("FAIL load_enter got=%b%b/%0d want=10/0", load_ready, fetch_ready, load_count);
        end
        for (int i = 0; i < DEPTH; i++) begin
            int gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                load_valid = 1'b0;
                load_data  = 16'($urandom);
                tick();
                if (load_done) pulses++;
            end
            load_valid = 1'b1;
            load_data  = words[i];
            tick();
            $display("load word=%0d data=%h count=%0d done=%b", i, words[i], load_count, load_done);
            if (load_done) pulses++;
            total++;
            if (load_count !== 4'(i + 1)) begin
                bad++; $display("FAIL load_count_step got=%0d want=%0d", load_count, i + 1);
            end
        end
        load_valid = 1'b0;
        total++;
        if (load_done !== 1'b1 || fetch_ready !== 1'b1) begin
            bad++; $display("FAIL load_done_pulse got=%b/%b want=1/1", load_done, fetch_ready);
        end
        tick();
        total++;
        if (load_done !== 1'b0 || pulses != 1 || load_count !== 4'd8) begin
            bad++; $display("FAIL load_done_once got=%b pulses=%0d count=%0d want=0/1/8", load_done, pulses, load_count);
        end
        for (int a = 0; a < DEPTH; a++) begin
            fetch_req  = 1'b1;
            fetch_addr = ADDR_W'(a);
            tick();
            $display("fetch addr=%0d inst=%h valid=%b", a, inst, inst_valid);
            total++;
            if (inst_valid !== 1'b1 || inst !== words[a]) begin
                bad++; $display("FAIL loaded_fetch addr=%0d got=%b/%h want=1/%h", a, inst_valid, inst, words[a]);
            end
        end
        fetch_req = 1'b0;
        tick();
    endtask

    task automatic test_fetch_with_start();
        fetch_req  = 1'b1;
        fetch_addr = 3'd1;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        $display("fetch addr=1 with load_start inst=%h valid=%b", inst, inst_valid);
        total++;
        if (inst_valid !== 1'b1 || inst !== 16'h140A) begin
            bad++; $display("FAIL fetch_at_start got=%b/%h want=1/140a", inst_valid, inst);
        end
        total++;
        if (fetch_ready !== 1'b0 || load_ready !== 1'b1) begin
            bad++; $display("FAIL ready_in_load got=%b%b want=01", fetch_ready, load_ready);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            total++;
            if (inst_valid !== 1'b0 || inst !== 16'h140A) begin
                bad++; $display("FAIL fetch_ignored_in_load got=%b/%h want=0/140a", inst_valid, inst);
            end
        end
        fetch_req = 1'b0;
    endtask

    task automatic test_restart();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            load_valid = 1'b1;
            load_data  = 16'hB000 + 16'(i);
            tick();
            total++;
            if (load_count !== 4'(i + 1)) begin
                bad++; $display("FAIL partial_count got=%0d want=%0d", load_count, i + 1);
            end
        end
        load_start = 1'b1;
        load_valid = 1'b1;
        load_data  = 16'hDEAD;
        tick();
        load_start = 1'b0;
        total++;
        if (load_count !== 4'd0 || load_ready !== 1'b1) begin
            bad++; $display("FAIL restart_clear got=%0d/%b want=0/1", load_count, load_ready);
        end
        for (int i = 0; i < DEPTH; i++) begin
            load_valid = 1'b1;
            load_data  = 16'hA000 + 16'(i);
            tick();
            $display("load word=%0d data=%h count=%0d done=%b", i, load_data, load_count, load_done);
            total++;
            if (load_count !== 4'(i + 1) || load_done !== (i == DEPTH - 1)) begin
                bad++; $display("FAIL restart_count got=%0d/%b want=%0d/%b", load_count, load_done, i + 1, i == DEPTH - 1);
            end
        end
        load_valid = 1'b0;
        for (int a = 0; a < DEPTH; a++) begin
            fetch_req  = 1'b1;
            fetch_addr = ADDR_W'(a);
            tick();
            total++;
            if (inst_valid !== 1'b1 || inst !== 16'hA000 + 16'(a)) begin
                bad++; $display("FAIL restart_fetch addr=%0d got=%b/%h want=1/%h", a, inst_valid, inst, 16'hA000 + 16'(a));
            end
        end
        fetch_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_midload();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            load_valid = 1'b1;
            load_data  = 16'hC000 + 16'(i);
            tick();
        end
        load_valid = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #1;
        total++;
        if (load_count !== 4'd0 || fetch_ready !== 1'b1 || load_ready !== 1'b0) begin
            bad++; $display("FAIL midload_reset got=%0d/%b%b want=0/10", load_count, fetch_ready, load_ready);
        end
        #1;
        rst_n = 1'b1;
        for (int a = 0; a < DEPTH; a++) begin
            fetch_req  = 1'b1;
            fetch_addr = ADDR_W'(a);
            tick();
            total++;
            if (inst_valid !== 1'b1 || inst !== NOP) begin
                bad++; $display("FAIL midload_fetch addr=%0d got=%b/%h want=1/%h", a, inst_valid, inst, NOP);
            end
        end
        fetch_req = 1'b0;
        tick();
    endtask

    task automatic test_fetch_held_in_load();
        int budget;
        logic [15:0] first_word;
        fetch_req  = 1'b1;
        fetch_addr = 3'd0;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        first_word = 16'($urandom);
        for (int i = 0; i < DEPTH; i++) begin
            load_valid = ($urandom_range(0, 3) != 0) || (i == 0);
            load_data  = (i == 0) ? first_word : 16'($urandom);
            if (!load_valid) begin
                tick();
                total++;
                if (inst_valid !== 1'b0) begin bad++; $display("FAIL held_fetch_gap got=%b want=0", inst_valid); end
                load_valid = 1'b1;
            end
            tick();
            total++;
            if (inst_valid !== 1'b0) begin bad++; $display("FAIL held_fetch_load got=%b want=0", inst_valid); end
        end
        load_valid = 1'b0;
        budget = 0;
        while (!inst_valid && budget < 4) begin
            tick();
            budget++;
        end
        total++;
        if (inst_valid !== 1'b1 || inst !== first_word || budget != 1) begin
            bad++; $display("FAIL first_run_fetch got=%b/%h after=%0d want=1/%h after=1", inst_valid, inst, budget, first_word);
        end
        fetch_req = 1'b0;
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            fetch_req  = $urandom_range(0, 1);
            fetch_addr = ADDR_W'($urandom);
            load_start = ($urandom_range(0, 39) == 0);
            load_valid = ($urandom_range(0, 9) < 6);
            load_data  = 16'($urandom);
            tick();
            total++;
            if (inst_valid !== exp_valid || inst !== exp_inst) begin
                bad++; $display("FAIL rand_inst cyc=%0d got=%b/%h want=%b/%h", c, inst_valid, inst, exp_valid, exp_inst);
            end
            total++;
            if (load_done !== exp_done || load_count !== 4'(m_count) || fetch_ready !== !m_load || load_ready !== m_load) begin
                bad++; $display("FAIL rand_load cyc=%0d got=%b/%0d/%b%b want=%b/%0d/%b%b", c, load_done, load_count,
                                fetch_ready, load_ready, exp_done, m_count, !m_load, m_load);
            end
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        test_reset();
        test_fetch_all();
        test_load_gaps();
        test_fetch_with_start();
        test_restart();
        test_reset_midload();
        test_fetch_held_in_load();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/program_mem.md
PROGRAM_MEM -- requirements
Module: program_mem

Interface
REQ-001 SHALL have parameter DATA_W, default 16: instruction word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 3: address width; DEPTH = 2**ADDR_W words.
REQ-003 SHALL have parameter NOP_WORD, default 16'h000F: word placed in every location at reset.
REQ-004 SHALL have port clk, input, 1: single clock; one clock, all state on rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port fetch_req, input, 1: fetch request.
REQ-007 SHALL have port fetch_addr, input, ADDR_W: fetch word address.
REQ-008 SHALL have port fetch_ready, output, 1: fetch can be accepted this cycle.
REQ-009 SHALL have port inst_valid, output, 1: inst carries fetched word this cycle.
REQ-010 SHALL have port inst, output, DATA_W: fetched instruction.
REQ-011 SHALL have port load_start, input, 1: begin program load from address 0.
REQ-012 SHALL have port load_valid, input, 1: load_data holds a word to write.
REQ-013 SHALL have port load_data, input, DATA_W: word to write.
REQ-014 SHALL have port load_ready, output, 1: load word can be accepted this cycle.
REQ-015 SHALL have port load_done, output, 1: one-cycle pulse, full program loaded.
REQ-016 SHALL have port load_count, output, ADDR_W+1: words written in current load.

Function
REQ-017 SHALL implement FSM with states RUN and LOAD; fetch_ready = (state==RUN), load_ready = (state==LOAD), both combinational from state.
REQ-018 In RUN, fetch accepted when fetch_req && fetch_ready; inst SHALL equal mem[fetch_addr] sampled at acceptance edge, with inst_valid=1, exactly one cycle later.
REQ-019 Back-to-back fetches SHALL sustain one word per cycle; inst_valid SHALL be 0 in any cycle not following an accepted fetch.
REQ-020 inst SHALL hold its last value when inst_valid=0.
REQ-021 RUN -> LOAD on load_start; load_count and write pointer SHALL clear to 0 on that edge.
REQ-022 A fetch accepted in the same cycle as load_start SHALL complete normally, returning pre-load contents.
REQ-023 In LOAD, each cycle with load_valid=1 SHALL write load_data to mem[ptr], increment ptr and load_count.
REQ-024 On the write that makes load_count reach DEPTH: LOAD -> RUN, load_done=1 for the following cycle only, ptr wraps to 0, load_count holds DEPTH until next load_start.
REQ-025 load_start while in LOAD SHALL restart the load: ptr and load_count to 0; a simultaneous load_valid word SHALL be discarded.
REQ-026 fetch_req in LOAD SHALL be ignored (no inst_valid); locations not yet rewritten keep prior contents.
REQ-027 New contents SHALL be visible to the first fetch accepted after returning to RUN.

Reset
REQ-028 On rst_n=0, asynchronously: state=RUN, every memory word=NOP_WORD, inst=0, inst_valid=0, load_done=0, load_count=0, ptr=0.
REQ-029 Reset asserted mid-load SHALL abort the load and discard all written words.
REQ-030 Outputs SHALL be stable and valid from the first rising edge after rst_n deasserts.

Verification
REQ-031 Reset, fetch addr 0..7 back-to-back -> inst=16'h000F, inst_valid=1 on 8 consecutive cycles, one cycle after each request.
REQ-032 load_start, then 8 words 16'h1215,16'h140A,16'h000F,16'h000F,16'hF201,16'hF402,16'hF203,16'hF404 with load_valid gaps -> load_done pulses once after 8th word; fetches 0..7 return those words in order.
REQ-033 fetch_req addr 1 and load_start same cycle -> inst=old mem[1], inst_valid=1 next cycle; fetch_ready=0 during load.
REQ-034 Load 3 words, assert load_start again, load 8 words 16'hA000..16'hA007 -> all 8 addresses read 16'hA000..16'hA007; load_count sequence 0..3, 0..8.
REQ-035 rst_n low after 5 load words -> state RUN, load_count=0, all addresses read 16'h000F.
REQ-036 fetch_req held high in LOAD -> no inst_valid until after load_done; first RUN fetch returns new contents.
